de0_vga: RTL and testbench



---
 rtl/de0_vga_pkg.sv | 32 +++
 rtl/de0_vga_axis.sv | 52 +++++
 rtl/de0_vga.sv | 124 ++++++++++++
 tb/tb_de0_vga.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/de0_vga_pkg.sv
// Shared timing defaults and types for the de0_vga raster generator.
package de0_vga_pkg;

   // Counter width: large enough for the default 1688-clock line.
   localparam int CW = 11;

   // Default 1280x1024@60 Hz timing (108 MHz pixel clock).
   localparam int H_ACTIVE_DEF = 1280;
   localparam int H_FRONT_DEF  = 48;
   localparam int H_SYNC_DEF   = 112;
   localparam int H_BACK_DEF   = 248;
   localparam int V_ACTIVE_DEF = 1024;
   localparam int V_FRONT_DEF  = 1;
   localparam int V_SYNC_DEF   = 3;
   localparam int V_BACK_DEF   = 38;

   localparam int H_TOTAL = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   // 4-4-4 colour as driven to the DAC pins.
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Pass the colour through inside the active area, black elsewhere.
   function automatic rgb444_t rgb_mask(input logic [11:0] color, input logic active);
      rgb_mask = active ? rgb444_t'(color) : '0;
   endfunction

endpackage

// File: rtl/de0_vga_axis.sv
// One raster axis: free-running counter over active/front/sync/back with
// zero-latency decode of visible and (active-high) sync from the count.
module de0_vga_axis
   import de0_vga_pkg::*;
#(
   parameter int ACTIVE = 1280,
   parameter int FRONT  = 48,
   parameter int SYNC   = 112,
   parameter int BACK   = 248
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          visible_o,
   output logic          sync_o,
   output logic          wrap_o
);

   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
   localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
   localparam logic [CW-1:0] A_END = CW'(ACTIVE);
   localparam logic [CW-1:0] S_BEG = CW'(ACTIVE + FRONT);
   localparam logic [CW-1:0] S_END = CW'(ACTIVE + FRONT + SYNC);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_last;

   // Next count: advance when enabled, wrap to 0 after the last position.
   always_comb begin
      at_last = (cnt_q == LAST);
      cnt_d   = cnt_q;
      if (en_i) begin
         cnt_d = at_last ? '0 : cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o   = cnt_q;
   assign visible_o = (cnt_q < A_END);
   assign sync_o    = (cnt_q >= S_BEG) && (cnt_q < S_END);
   assign wrap_o    = en_i && at_last;

endmodule

// File: rtl/de0_vga.sv
// VGA raster generator and pixel output stage: H/V axes, coordinate and
// visibility decode, PIPE-deep sync delay, masked colour register and a
// frame counter.
module de0_vga
   import de0_vga_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FRONT  = H_FRONT_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BACK   = H_BACK_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FRONT  = V_FRONT_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BACK   = V_BACK_DEF,
   parameter logic SYNC_POL = 1'b1,
   parameter int   PIPE     = 2          // must be >= 1
) (
   input  logic          clk_50,
   input  logic          rst_n,
   input  logic [11:0]   pixel_color,
   output logic [3:0]    VGA_BUS_R,
   output logic [3:0]    VGA_BUS_G,
   output logic [3:0]    VGA_BUS_B,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic [CW-1:0] X_pix,
   output logic [CW-1:0] Y_pix,
   output logic          H_visible,
   output logic          V_visible,
   output logic          pixel_clk,
   output logic [9:0]    pixel_cnt
);

   // Colour is registered once at the end, so the visibility flag needs
   // PIPE-1 stages ahead of that register to land with the sync pins.
   localparam int VDLY = PIPE - 1;

   logic [CW-1:0] hc, vc;
   logic          h_vis, v_vis, h_sync, v_sync, h_wrap, v_wrap;
   logic          vis_now, vis_tap;
   logic [1:0]    sync_sr_q [PIPE];   // {hs, vs}, active-high internally
   rgb444_t       rgb_q, rgb_d;
   logic [9:0]    frame_q, frame_d;

   de0_vga_axis #(
      .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
   ) u_h_axis (
      .clk_i(clk_50), .rst_ni(rst_n), .en_i(1'b1),
      .count_o(hc), .visible_o(h_vis), .sync_o(h_sync), .wrap_o(h_wrap)
   );

   de0_vga_axis #(
      .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
   ) u_v_axis (
      .clk_i(clk_50), .rst_ni(rst_n), .en_i(h_wrap),
      .count_o(vc), .visible_o(v_vis), .sync_o(v_sync), .wrap_o(v_wrap)
   );

   assign vis_now = h_vis & v_vis;

   generate
      if (VDLY == 0) begin : g_vis_nodly
         assign vis_tap = vis_now;
      end else begin : g_vis_dly
         logic [VDLY-1:0] vis_sr_q;
         // Visibility delay line feeding the colour mask.
         always_ff @(posedge clk_50 or negedge rst_n) begin
            if (!rst_n) begin
               vis_sr_q <= '0;
            end else begin
               vis_sr_q[0] <= vis_now;
               for (int i = 1; i < VDLY; i++) begin
                  vis_sr_q[i] <= vis_sr_q[i-1];
               end
            end
         end
         assign vis_tap = vis_sr_q[VDLY-1];
      end
   endgenerate

   // Sync delay line; reset fills it inactive so no partial pulse follows.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE; i++) begin
            sync_sr_q[i] <= 2'b00;
         end
      end else begin
         sync_sr_q[0] <= {h_sync, v_sync};
         for (int i = 1; i < PIPE; i++) begin
            sync_sr_q[i] <= sync_sr_q[i-1];
         end
      end
   end

   // Next colour and frame count.
   always_comb begin
      rgb_d   = rgb_mask(pixel_color, vis_tap);
      frame_d = v_wrap ? frame_q + 10'd1 : frame_q;
   end

   // Colour output register and frame counter.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q   <= '0;
         frame_q <= '0;
      end else begin
         rgb_q   <= rgb_d;
         frame_q <= frame_d;
      end
   end

   assign VGA_BUS_R = rgb_q.r;
   assign VGA_BUS_G = rgb_q.g;
   assign VGA_BUS_B = rgb_q.b;
   assign VGA_HS    = sync_sr_q[PIPE-1][1] ? SYNC_POL : ~SYNC_POL;
   assign VGA_VS    = sync_sr_q[PIPE-1][0] ? SYNC_POL : ~SYNC_POL;
   assign X_pix     = h_vis ? hc : '0;
   assign Y_pix     = v_vis ? vc : '0;
   assign H_visible = h_vis;
   assign V_visible = v_vis;
   assign pixel_clk = clk_50;
   assign pixel_cnt = frame_q;

endmodule

// File: tb/tb_de0_vga.sv
// Bench for de0_vga: small-parameter instance checked cycle by cycle against
// a timing model through an expected queue, plus directed timing checks on
// the small, default-parameter and tiny (frame-counter wrap) instances.
`timescale 1ns/1ps
module tb_de0_vga;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [11:0] pixel_color;

  // small instance: H 8/2/2/2 (14), V 4/1/1/1 (7), frame 98
  logic [3:0]  r_r, r_g, r_b;
  logic        r_hs, r_vs, r_hv, r_vv, r_pclk;
  logic [10:0] r_x, r_y;
  logic [9:0]  r_pcnt;
  // default instance
  logic [3:0]  d_r, d_g, d_b;
  logic        d_hs, d_vs, d_hv, d_vv, d_pclk;
  logic [10:0] d_x, d_y;
  logic [9:0]  d_pcnt;
  // tiny instance: H 2/1/1/1 (5), V 1/1/1/1 (4), frame 20
  logic [3:0]  w_r, w_g, w_b;
  logic        w_hs, w_vs, w_hv, w_vv, w_pclk;
  logic [10:0] w_x, w_y;
  logic [9:0]  w_pcnt;

  de0_vga #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
            .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
            .SYNC_POL(1'b1), .PIPE(2)) dut (
    .clk_50(clk), .rst_n(rst_n), .pixel_color(pixel_color),
    .VGA_BUS_R(r_r), .VGA_BUS_G(r_g), .VGA_BUS_B(r_b),
    .VGA_HS(r_hs), .VGA_VS(r_vs), .X_pix(r_x), .Y_pix(r_y),
    .H_visible(r_hv), .V_visible(r_vv), .pixel_clk(r_pclk), .pixel_cnt(r_pcnt));

  de0_vga dut_d (
    .clk_50(clk), .rst_n(rst_n), .pixel_color(pixel_color),
    .VGA_BUS_R(d_r), .VGA_BUS_G(d_g), .VGA_BUS_B(d_b),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .X_pix(d_x), .Y_pix(d_y),
    .H_visible(d_hv), .V_visible(d_vv), .pixel_clk(d_pclk), .pixel_cnt(d_pcnt));

  de0_vga #(.H_ACTIVE(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
            .V_ACTIVE(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
            .SYNC_POL(1'b1), .PIPE(2)) dut_w (
    .clk_50(clk), .rst_n(rst_n), .pixel_color(pixel_color),
    .VGA_BUS_R(w_r), .VGA_BUS_G(w_g), .VGA_BUS_B(w_b),
    .VGA_HS(w_hs), .VGA_VS(w_vs), .X_pix(w_x), .Y_pix(w_y),
    .H_visible(w_hv), .V_visible(w_vv), .pixel_clk(w_pclk), .pixel_cnt(w_pcnt));

  // ---------------- scoreboard ----------------
  int checks_total  = 0;
  int checks_passed = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Timing model of the small instance (state after the most recent edge).
  int         m_hc, m_vc, m_pcnt;
  logic       m_vis1, m_hs1, m_hs2, m_vs1, m_vs2;
  logic [11:0] m_rgb;

  task automatic model_reset();
    m_hc = 0; m_vc = 0; m_pcnt = 0;
    m_vis1 = 0; m_hs1 = 0; m_hs2 = 0; m_vs1 = 0; m_vs2 = 0;
    m_rgb = '0;
  endtask

  task automatic model_edge();
    m_rgb  = m_vis1 ? pixel_color : 12'h000;
    m_vis1 = (m_hc < 8) && (m_vc < 4);
    m_hs2  = m_hs1;
    m_hs1  = (m_hc >= 10) && (m_hc < 12);
    m_vs2  = m_vs1;
    m_vs1  = (m_vc == 5);
    if (m_hc == 13) begin
      m_hc = 0;
      if (m_vc == 6) begin
        m_vc = 0;
        m_pcnt = (m_pcnt + 1) % 1024;
      end else begin
        m_vc++;
      end
    end else begin
      m_hc++;
    end
  endtask

  function automatic logic [47:0] model_out();
    logic [10:0] x, y;
    x = (m_hc < 8) ? 11'(m_hc) : 11'd0;
    y = (m_vc < 4) ? 11'(m_vc) : 11'd0;
    return {x, y, (m_hc < 8), (m_vc < 4), m_hs2, m_vs2, m_rgb, 10'(m_pcnt)};
  endfunction

  // Monitor: every cycle the DUT presents a new output word; compare it.
  initial begin
    logic [47:0] got;
    forever begin
      @(negedge clk);
      got = {r_x, r_y, r_hv, r_vv, r_hs, r_vs, r_r, r_g, r_b, r_pcnt};
      if (exp_q.size() > 0) check("cycle", got, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst_val, input logic [11:0] col);
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    rst_n = rst_val;
    if (!rst_n) model_reset();
    pixel_color = col;
    exp_q.push_back(model_out());
  endtask

  int w_hs_hi, w_vs_hi, w_hv_hi, w_rise1, w_rise2, w_rgb1;
  int w_pc[$];

  // Run n clocks from the current state, tallying the small instance pins.
  task automatic run_window(input int n, input bit vary);
    logic       prev_hs;
    logic [9:0] prev_pc;
    w_hs_hi = 0; w_vs_hi = 0; w_hv_hi = 0;
    w_rise1 = -1; w_rise2 = -1; w_rgb1 = -1;
    w_pc.delete();
    prev_hs = r_hs;
    prev_pc = r_pcnt;
    for (int k = 1; k <= n; k++) begin
      step(1'b1, vary ? 12'(12'h5A0 + k * 37) : 12'hABC);
      @(negedge clk);
      if (r_hs) w_hs_hi++;
      if (r_vs) w_vs_hi++;
      if (r_hv) w_hv_hi++;
      if (r_hs && !prev_hs) begin
        if (w_rise1 < 0) w_rise1 = k;
        else if (w_rise2 < 0) w_rise2 = k;
      end
      prev_hs = r_hs;
      if (w_rgb1 < 0 && {r_r, r_g, r_b} != 12'h000) w_rgb1 = k;
      if (r_pcnt != prev_pc) w_pc.push_back(k);
      prev_pc = r_pcnt;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d_rise1, d_rise2, d_vs_hi, k;
    logic d_prev_hs;
    rst_n = 1'b0;
    pixel_color = 12'hABC;
    model_reset();

    // Reset values held.
    repeat (3) step(1'b0, 12'hABC);
    @(negedge clk);
    check("reset_pins", {r_x, r_y, r_hs, r_vs, r_r, r_g, r_b, r_pcnt}, 48'd0);
    check("reset_vis", {r_hv, r_vv}, 2'b11);

    // Release, then three full frames with constant colour.
    step(1'b1, 12'hABC);
    run_window(294, 1'b0);
    check("hs_high_clocks", w_hs_hi, 42);
    check("vs_high_clocks", w_vs_hi, 42);
    check("hvis_clocks", w_hv_hi, 168);
    check("hs_first_rise", w_rise1, 12);
    check("line_period", w_rise2 - w_rise1, 14);
    check("first_rgb", w_rgb1, 2);
    check("frame_evt0", (w_pc.size() > 0) ? w_pc[0] : -1, 98);
    check("frame_evt1", (w_pc.size() > 1) ? w_pc[1] : -1, 196);
    check("frame_evt2", (w_pc.size() > 2) ? w_pc[2] : -1, 294);
    check("pcnt_3", r_pcnt, 10'd3);

    // Changing colour: alignment is covered by the per-cycle scoreboard.
    run_window(120, 1'b1);

    // Mid-frame reset at hc=5, vc=2.
    step(1'b0, 12'hABC);
    step(1'b1, 12'hABC);
    repeat (32) step(1'b1, 12'hABC);
    step(1'b0, 12'hABC);
    @(negedge clk);
    check("midrst_pins", {r_x, r_y, r_hs, r_vs, r_r, r_g, r_b, r_pcnt}, 48'd0);
    check("midrst_vis", {r_hv, r_vv}, 2'b11);
    step(1'b0, 12'hABC);
    step(1'b1, 12'hABC);
    run_window(100, 1'b0);
    check("midrst_hs_rise", w_rise1, 12);
    check("midrst_first_rgb", w_rgb1, 2);
    check("midrst_frame_evt", (w_pc.size() > 0) ? w_pc[0] : -1, 98);

    // Default parameters: one line and a bit.
    step(1'b0, 12'hABC);
    step(1'b1, 12'hABC);
    d_rise1 = -1; d_rise2 = -1; d_vs_hi = 0; d_prev_hs = d_hs;
    for (int j = 1; j <= 3100; j++) begin
      step(1'b1, 12'hABC);
      @(negedge clk);
      if (d_hs && !d_prev_hs) begin
        if (d_rise1 < 0) d_rise1 = j;
        else if (d_rise2 < 0) d_rise2 = j;
      end
      d_prev_hs = d_hs;
      if (d_vs) d_vs_hi++;
      if (j == 1279) begin
        check("def_x_last", d_x, 11'd1279);
        check("def_hvis_last", d_hv, 1'b1);
      end
      if (j == 1280) check("def_hvis_off", d_hv, 1'b0);
      if (j == 1688) check("def_y_line1", {d_x, d_y}, {11'd0, 11'd1});
    end
    check("def_hs_rise", d_rise1, 1330);
    check("def_line_period", d_rise2 - d_rise1, 1688);
    check("def_vs_idle", d_vs_hi, 0);

    // Tiny instance: frame counter wrap 1023 -> 0 (20 clocks per frame).
    step(1'b0, 12'hABC);
    step(1'b1, 12'hABC);
    k = 0;
    repeat (20480) begin
      step(1'b1, 12'hABC);
      k++;
      if (k == 20 || k == 20460 || k == 20480) begin
        @(negedge clk);
        if (k == 20)    check("tiny_pcnt_1", w_pcnt, 10'd1);
        if (k == 20460) check("tiny_pcnt_1023", w_pcnt, 10'd1023);
        if (k == 20480) check("tiny_pcnt_wrap", {w_pcnt, w_x, w_y}, {10'd0, 11'd0, 11'd0});
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
